fpnew_result_fifo: RTL and testbench
====================================

# fpnew_result_fifo

- Buffering stage directly downstream of an operation-group block.
- Accepts one result per handshake: result word, 5-bit IEEE status, extension bit, tag.
- Holds results in a circular FIFO of `Depth` entries and releases them in order through a valid/ready output port.
- Accumulates the status of every retired result into a sticky `fflags_o` register for the CSR side.

## Interface

Parameters:
- `Width`, 32: result word width in bits.
- `Depth`, 4: FIFO entries, ≥1; need not be a power of two.
- `TagType`, logic: tag type carried alongside each result.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  upstream result valid.
- `in_ready_o`  out  1  FIFO can accept a result.
- `result_i`  in  Width  upstream result.
- `status_i`  in  5  upstream status {NV,DZ,OF,UF,NX}.
- `extension_bit_i`  in  1  upstream extension bit.
- `tag_i`  in  $bits(TagType)  upstream tag.
- `flush_i`  in  1  discard all buffered entries.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  consumer accepts head.
- `result_o`  out  Width  head result.
- `status_o`  out  5  head status.
- `extension_bit_o`  out  1  head extension bit.
- `tag_o`  out  $bits(TagType)  head tag.
- `fflags_clr_i`  in  1  clear sticky flags.
- `fflags_o`  out  5  sticky OR of retired statuses.
- `count_o`  out  $clog2(Depth+1)  occupied entries.
- `busy_o`  out  1  `count_o != 0`.

## Operation

- Push: `in_valid_i & in_ready_o`; the entry is written at the write pointer. Pop: `out_valid_o & out_ready_i`; the read pointer advances.
- Pointers wrap from `Depth-1` to 0; `count_o` is the explicit occupancy and tracks pointer wrap.
- `in_ready_o = (count_o != Depth)`. Ready never depends combinationally on `out_ready_i`.
- `out_valid_o = (count_o != 0)`. Outputs present the head entry. Data outputs are don't-care when `out_valid_o=0`.
- Push and pop in the same cycle: pointers both advance and count is unchanged. When full this cannot happen, because the push is blocked.
- `flush_i`:
  - Next cycle: count=0 and pointers=0.
  - A push or pop offered in the flush cycle is dropped, and the popped status is not accumulated.
  - `fflags_o` is not affected by flush.
- Sticky flags:
  - On every pop, `fflags_o <= fflags_o | status_o`.
  - With `fflags_clr_i=1`, `fflags_o <= (pop ? status_o : 0)`; clear is applied first, then the set.
- Reset: count, pointers and `fflags_o` become 0. `out_valid_o=0`, `in_ready_o=1`, `busy_o=0`, `count_o=0`. Data outputs are don't-care.
- Reset applied mid-operation discards all entries, with identical effect to a flush plus a flags clear.

## Timing

- Without fallthrough: push-to-`out_valid_o` latency is 1 cycle. Throughput is 1 result/cycle while neither full nor empty.
- `fflags_o` updates on the clock edge after the pop.
- All outputs are registered or decoded from registered state. The only exception is the fallthrough path described under Configuration.
- `count_o` and `busy_o` reflect state after the last edge.

## Configuration

- `FPNEW_RESULT_FIFO_FALLTHROUGH_EN` defined:
  - When count=0 and `in_valid_i=1`, `out_valid_o=1` in the same cycle and the data outputs mux the input fields.
  - If `out_ready_i=1` in that cycle, the entry is consumed without being written: count stays 0 and the status is accumulated into `fflags_o`. Otherwise the entry is written normally.
  - Latency is 0 cycles when empty.
- Undefined: no combinational input-to-output path; latency is 1 cycle as above.

## Test plan

- Reset, then idle → `out_valid_o=0`, `in_ready_o=1`, `count_o=0`, `fflags_o=5'b0`.
- Depth=4: push tags 1..5 with `out_ready_i=0` → `in_ready_o` drops after the 4th push, `count_o=4`, tag 5 held off. Pop all four → tags come out in order 1,2,3,4.
- Continuous push+pop for 10 cycles with Depth=3 → count holds constant, pointers wrap, tags come out in order with no loss.
- Pop statuses 5'b00001 then 5'b10000 → `fflags_o=5'b10001`. Assert `fflags_clr_i` together with a pop of status 5'b00100 → `fflags_o=5'b00100`.
- Fill with 2 entries, assert `flush_i` with a simultaneous push and pop → next cycle count=0 and `out_valid_o=0`, `fflags_o` unchanged.
- Fallthrough build: when empty, `in_valid_i=1` with tag 7 and `out_ready_i=1` → same-cycle `out_valid_o=1`, `tag_o=7`, count stays 0. Without the macro, the same stimulus gives `out_valid_o` one cycle later.

Source files
------------

// File: rtl/fpnew_result_fifo.sv
// Result buffer behind an operation group: circular FIFO with in-order release and sticky status flags.
// Define FPNEW_RESULT_FIFO_FALLTHROUGH_EN for a same-cycle bypass from input to output when empty.
module fpnew_result_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [Width-1:0]             result_i,
  input  logic [4:0]                   status_i,
  input  logic                         extension_bit_i,
  input  TagType                       tag_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             result_o,
  output logic [4:0]                   status_o,
  output logic                         extension_bit_o,
  output TagType                       tag_o,
  input  logic                         fflags_clr_i,
  output logic [4:0]                   fflags_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [Width-1:0] result;
    logic [4:0]       status;
    logic             ext;
    TagType           tag;
  } entry_t;

  entry_t            mem [Depth];
  entry_t            in_entry;
  entry_t            head_entry;
  logic [PtrW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0]   count_reg, count_next;
  logic [4:0]        fflags_reg, fflags_next;
  logic              head_valid;
  logic              ft_active;
  logic              push, pop, mem_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_entry   = '{result: result_i, status: status_i, ext: extension_bit_i, tag: tag_i};
  assign head_valid = (count_reg != '0);
  assign in_ready_o = (count_reg != CntW'(Depth));

`ifdef FPNEW_RESULT_FIFO_FALLTHROUGH_EN
  // Empty FIFO: present the incoming result directly so it can retire this cycle.
  assign ft_active  = !head_valid && in_valid_i;
  assign head_entry = ft_active ? in_entry : mem[rd_ptr_reg];
`else
  assign ft_active  = 1'b0;
  assign head_entry = mem[rd_ptr_reg];
`endif

  assign out_valid_o     = head_valid | ft_active;
  assign result_o        = head_entry.result;
  assign status_o        = head_entry.status;
  assign extension_bit_o = head_entry.ext;
  assign tag_o           = head_entry.tag;

  // A bypassed result consumed in the same cycle never occupies a slot.
  assign pop     = out_valid_o && out_ready_i && !flush_i;
  assign mem_pop = pop && head_valid;
  assign push    = in_valid_i && in_ready_o && !flush_i && !(ft_active && out_ready_i);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    fflags_next = fflags_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (mem_pop) rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push, mem_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
    // Clear first, then OR in the status retiring this cycle.
    if (fflags_clr_i) fflags_next = '0;
    if (pop) fflags_next = fflags_next | status_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fflags_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      fflags_reg <= fflags_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= in_entry;
  end

  assign fflags_o = fflags_reg;
  assign count_o  = count_reg;
  assign busy_o   = (count_reg != '0);

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Directed bench for fpnew_result_fifo: a Depth=4 vector table plus Depth=3 streaming, latency and reset sequences.
module tb_fpnew_result_fifo;

  typedef logic [3:0] tag_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_iv, a_ir, a_ext_i, a_flush, a_ov, a_ordy, a_ext_o, a_clr, a_busy;
  logic [31:0] a_res_i, a_res_o;
  logic [4:0]  a_st_i, a_st_o, a_ff;
  tag_t        a_tag_i, a_tag_o;
  logic [2:0]  a_cnt;

  logic        b_iv, b_ir, b_ext_i, b_flush, b_ov, b_ordy, b_ext_o, b_clr, b_busy;
  logic [31:0] b_res_i, b_res_o;
  logic [4:0]  b_st_i, b_st_o, b_ff;
  tag_t        b_tag_i, b_tag_o;
  logic [1:0]  b_cnt;

  fpnew_result_fifo #(.Width(32), .Depth(4), .TagType(tag_t)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .result_i(a_res_i),
    .status_i(a_st_i), .extension_bit_i(a_ext_i), .tag_i(a_tag_i), .flush_i(a_flush),
    .out_valid_o(a_ov), .out_ready_i(a_ordy), .result_o(a_res_o), .status_o(a_st_o),
    .extension_bit_o(a_ext_o), .tag_o(a_tag_o), .fflags_clr_i(a_clr), .fflags_o(a_ff),
    .count_o(a_cnt), .busy_o(a_busy)
  );

  fpnew_result_fifo #(.Width(32), .Depth(3), .TagType(tag_t)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .result_i(b_res_i),
    .status_i(b_st_i), .extension_bit_i(b_ext_i), .tag_i(b_tag_i), .flush_i(b_flush),
    .out_valid_o(b_ov), .out_ready_i(b_ordy), .result_o(b_res_o), .status_o(b_st_o),
    .extension_bit_o(b_ext_o), .tag_o(b_tag_o), .fflags_clr_i(b_clr), .fflags_o(b_ff),
    .count_o(b_cnt), .busy_o(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic iv, input tag_t tag, input logic [4:0] st,
                         input logic ordy, input logic fl, input logic clr);
    a_iv    = iv;
    a_tag_i = tag;
    a_res_i = 32'hA000_0000 | {28'h0, tag};
    a_ext_i = tag[0];
    a_st_i  = st;
    a_ordy  = ordy;
    a_flush = fl;
    a_clr   = clr;
  endtask

  typedef struct {
    logic       iv;
    tag_t       tag;
    logic [4:0] st;
    logic       ordy, fl, clr;
    logic       e_ov, e_ir;
    logic [2:0] e_cnt;
    tag_t       e_tag;
    logic [4:0] e_ff;
  } vec_t;

  function automatic vec_t mk(input logic iv, input int tag, input logic [4:0] st,
                              input logic ordy, input logic fl, input logic clr,
                              input logic e_ov, input logic e_ir, input int e_cnt,
                              input int e_tag, input logic [4:0] e_ff);
    vec_t v;
    v.iv = iv; v.tag = tag_t'(tag); v.st = st; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = 3'(e_cnt); v.e_tag = tag_t'(e_tag); v.e_ff = e_ff;
    return v;
  endfunction

  vec_t vt [18];
  tag_t q [$];

  initial begin
    logic       e_ov;
    tag_t       e_tag;
    logic [31:0] e_res;

    rst = 1'b1;
    drive_a(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    b_iv = 0; b_tag_i = '0; b_res_i = '0; b_ext_i = 0; b_st_i = '0;
    b_ordy = 0; b_flush = 0; b_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //          iv tag st        ordy fl clr | ov ir cnt tag ff
    vt[0]  = mk(0, 0, 5'b00000, 0, 0, 0,   0, 1, 0, 0, 5'b00000);
    vt[1]  = mk(1, 1, 5'b00001, 0, 0, 0,   0, 1, 0, 0, 5'b00000);
    vt[2]  = mk(1, 2, 5'b10000, 0, 0, 0,   1, 1, 1, 1, 5'b00000);
    vt[3]  = mk(1, 3, 5'b00100, 0, 0, 0,   1, 1, 2, 1, 5'b00000);
    vt[4]  = mk(1, 4, 5'b00010, 0, 0, 0,   1, 1, 3, 1, 5'b00000);
    vt[5]  = mk(1, 5, 5'b11111, 0, 0, 0,   1, 0, 4, 1, 5'b00000);
    vt[6]  = mk(1, 5, 5'b11111, 1, 0, 0,   1, 0, 4, 1, 5'b00000);
    vt[7]  = mk(0, 0, 5'b00000, 1, 0, 0,   1, 1, 3, 2, 5'b00001);
    vt[8]  = mk(0, 0, 5'b00000, 1, 0, 1,   1, 1, 2, 3, 5'b10001);
    vt[9]  = mk(0, 0, 5'b00000, 1, 0, 0,   1, 1, 1, 4, 5'b00100);
    vt[10] = mk(0, 0, 5'b00000, 0, 0, 0,   0, 1, 0, 0, 5'b00110);
    vt[11] = mk(1, 6, 5'b01000, 0, 0, 0,   0, 1, 0, 0, 5'b00110);
    vt[12] = mk(1, 7, 5'b00001, 0, 0, 0,   1, 1, 1, 6, 5'b00110);
    vt[13] = mk(1, 8, 5'b10000, 1, 1, 0,   1, 1, 2, 6, 5'b00110);
    vt[14] = mk(0, 0, 5'b00000, 0, 0, 0,   0, 1, 0, 0, 5'b00110);
    vt[15] = mk(1, 9, 5'b00000, 0, 0, 0,   0, 1, 0, 0, 5'b00110);
    vt[16] = mk(0, 0, 5'b00000, 1, 0, 0,   1, 1, 1, 9, 5'b00110);
    vt[17] = mk(0, 0, 5'b00000, 0, 0, 0,   0, 1, 0, 0, 5'b00110);

    for (int i = 0; i < 18; i++) begin
      drive_a(vt[i].iv, vt[i].tag, vt[i].st, vt[i].ordy, vt[i].fl, vt[i].clr);
      #2;
      e_ov  = vt[i].e_ov;
      e_tag = vt[i].e_tag;
`ifdef FPNEW_RESULT_FIFO_FALLTHROUGH_EN
      if (vt[i].e_cnt == 3'd0 && vt[i].iv) begin
        e_ov  = 1'b1;
        e_tag = vt[i].tag;
      end
`endif
      e_res = 32'hA000_0000 | {28'h0, e_tag};
      $display("row %0d: iv=%0b tag=%0d ordy=%0b flush=%0b clr=%0b -> ov=%0b ir=%0b cnt=%0d tag_o=%0d ff=%05b",
               i, vt[i].iv, vt[i].tag, vt[i].ordy, vt[i].fl, vt[i].clr, a_ov, a_ir, a_cnt, a_tag_o, a_ff);
      chk("out_valid", i, 32'(a_ov), 32'(e_ov));
      chk("in_ready", i, 32'(a_ir), 32'(vt[i].e_ir));
      chk("count", i, 32'(a_cnt), 32'(vt[i].e_cnt));
      chk("busy", i, 32'(a_busy), 32'(vt[i].e_cnt != 3'd0));
      chk("fflags", i, 32'(a_ff), 32'(vt[i].e_ff));
      if (e_ov) begin
        chk("tag_o", i, 32'(a_tag_o), 32'(e_tag));
        chk("result_o", i, a_res_o, e_res);
        chk("ext_o", i, 32'(a_ext_o), 32'(e_tag[0]));
      end
      step();
    end

    // Latency from an empty FIFO with the consumer ready.
    drive_a(1'b1, 4'd7, 5'b10000, 1'b1, 1'b0, 1'b0);
    #2;
    $display("lat: empty push tag 7 -> ov=%0b tag_o=%0d cnt=%0d", a_ov, a_tag_o, a_cnt);
`ifdef FPNEW_RESULT_FIFO_FALLTHROUGH_EN
    chk("lat_ov0", 0, 32'(a_ov), 32'd1);
    chk("lat_tag0", 0, 32'(a_tag_o), 32'd7);
    chk("lat_cnt0", 0, 32'(a_cnt), 32'd0);
    step();
    drive_a(1'b0, 4'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
    #2;
    chk("lat_cnt1", 1, 32'(a_cnt), 32'd0);
    chk("lat_ov1", 1, 32'(a_ov), 32'd0);
`else
    chk("lat_ov0", 0, 32'(a_ov), 32'd0);
    chk("lat_cnt0", 0, 32'(a_cnt), 32'd0);
    step();
    drive_a(1'b0, 4'd0, 5'b00000, 1'b1, 1'b0, 1'b0);
    #2;
    $display("lat: next cycle -> ov=%0b tag_o=%0d cnt=%0d", a_ov, a_tag_o, a_cnt);
    chk("lat_ov1", 1, 32'(a_ov), 32'd1);
    chk("lat_tag1", 1, 32'(a_tag_o), 32'd7);
    chk("lat_cnt1", 1, 32'(a_cnt), 32'd1);
    step();
    drive_a(1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lat_cnt2", 2, 32'(a_cnt), 32'd0);
`endif
    step();
    drive_a(1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lat_ff", 0, 32'(a_ff), 32'b10110);

    // Depth=3: prefill two entries, then stream push+pop for 10 cycles across pointer wrap.
    q = {};
    for (int k = 1; k <= 2; k++) begin
      b_iv = 1; b_tag_i = tag_t'(k); b_res_i = 32'(k); b_st_i = '0; b_ordy = 0;
      q.push_back(tag_t'(k));
      step();
    end
    for (int k = 0; k < 10; k++) begin
      b_iv = 1; b_tag_i = tag_t'(k + 3); b_res_i = 32'(k + 3); b_ordy = 1;
      #2;
      $display("stream %0d: push tag %0d, pop tag %0d, cnt=%0d", k, k + 3, b_tag_o, b_cnt);
      chk("stream_cnt", k, 32'(b_cnt), 32'd2);
      chk("stream_ov", k, 32'(b_ov), 32'd1);
      chk("stream_tag", k, 32'(b_tag_o), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(tag_t'(k + 3));
      step();
    end
    b_iv = 0; b_ordy = 0;
    #2;
    chk("stream_end_cnt", 0, 32'(b_cnt), 32'd2);
    chk("stream_end_tag", 0, 32'(b_tag_o), 32'(q[0]));

    // Reset mid-operation discards entries and clears flags.
    step();
    drive_a(1'b1, 4'd1, 5'b00001, 1'b0, 1'b0, 1'b0);
    step();
    drive_a(1'b1, 4'd2, 5'b00001, 1'b0, 1'b0, 1'b0);
    step();
    drive_a(1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("pre_rst_cnt", 0, 32'(a_cnt), 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    $display("mid reset: ov=%0b ir=%0b cnt=%0d ff=%05b", a_ov, a_ir, a_cnt, a_ff);
    chk("rst_cnt", 0, 32'(a_cnt), 32'd0);
    chk("rst_ov", 0, 32'(a_ov), 32'd0);
    chk("rst_ir", 0, 32'(a_ir), 32'd1);
    chk("rst_busy", 0, 32'(a_busy), 32'd0);
    chk("rst_ff", 0, 32'(a_ff), 32'd0);
    chk("rst_b_cnt", 0, 32'(b_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
